// File: rtl/eq_pkg.sv
// Shared sizing constants and FSM encoding for the stereo EQ band scheduler.
package eq_pkg;

  localparam int NUM_BANDS   = 8;
  localparam int SAMPLE_W    = 24;
  localparam int GAIN_W      = 4;
  localparam int ACC_W       = 31;
  localparam int UNITY_SHIFT = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    OUT
  } eq_state_t;

endpackage

// File: rtl/eq_gain_mac.sv
// Per-band gain multiply-accumulate with >>>3 unity scaling.
// Define EQ_SAT_EN to clip the channel result instead of wrapping it.
module eq_gain_mac #(
  parameter int SAMPLE_W = eq_pkg::SAMPLE_W,
  parameter int GAIN_W   = eq_pkg::GAIN_W,
  parameter int ACC_W    = eq_pkg::ACC_W
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       clear,
  input  logic                       accumulate,
  input  logic                       last,
  input  logic signed [SAMPLE_W-1:0] data,
  input  logic        [GAIN_W-1:0]   gain,
  output logic signed [SAMPLE_W-1:0] result
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  scaled;

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  assign prod     = PROD_W'(data) * PROD_W'($signed({1'b0, gain}));
  assign acc_next = acc + ACC_W'(prod);
  assign scaled   = acc_next >>> eq_pkg::UNITY_SHIFT;

`ifdef EQ_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    if (scaled > MAX_V)
      result = MAX_V[SAMPLE_W-1:0];
    else if (scaled < MIN_V)
      result = MIN_V[SAMPLE_W-1:0];
    else
      result = scaled[SAMPLE_W-1:0];
  end
`else
  assign result = SAMPLE_W'(scaled);
`endif

  // The last band of a channel consumes the sum and restarts from zero.
  always_ff @(posedge clk) begin
    if (!nreset || clear || (accumulate && last))
      acc <= '0;
    else if (accumulate)
      acc <= acc_next;
  end

endmodule

// File: rtl/eq_band_sched.sv
// Stereo EQ frame scheduler: walks left then right bands through an external band filter.
// Build option EQ_SAT_EN selects saturating channel results (default wraps).
module eq_band_sched #(
  parameter int NUM_BANDS = eq_pkg::NUM_BANDS,
  parameter int SAMPLE_W  = eq_pkg::SAMPLE_W,
  parameter int GAIN_W    = eq_pkg::GAIN_W
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           newsample,
  input  logic signed [SAMPLE_W-1:0]     left_in,
  input  logic signed [SAMPLE_W-1:0]     right_in,
  input  logic                           eq_load,
  input  logic [NUM_BANDS*GAIN_W-1:0]    eq_vals,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [$clog2(NUM_BANDS)-1:0]   req_band,
  output logic                           req_ch,
  output logic signed [SAMPLE_W-1:0]     req_sample,
  input  logic                           resp_valid,
  input  logic signed [SAMPLE_W-1:0]     resp_data,
  output logic signed [SAMPLE_W-1:0]     out_left,
  output logic signed [SAMPLE_W-1:0]     out_right,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           overrun
);

  import eq_pkg::*;

  localparam int BAND_W = $clog2(NUM_BANDS);
  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << UNITY_SHIFT);
  localparam logic [NUM_BANDS*GAIN_W-1:0] GAIN_RESET = {NUM_BANDS{GAIN_UNITY}};

  eq_state_t                     state;
  logic [NUM_BANDS*GAIN_W-1:0]   gains;
  logic [NUM_BANDS*GAIN_W-1:0]   pend_vals;
  logic                          pend_valid;
  logic signed [SAMPLE_W-1:0]    right_s;
  logic signed [SAMPLE_W-1:0]    left_res;
  logic signed [SAMPLE_W-1:0]    mac_result;
  logic [GAIN_W-1:0]             band_gain;
  logic                          last_band;
  logic                          mac_accumulate;
  logic                          mac_clear;

  assign band_gain      = gains[int'(req_band)*GAIN_W +: GAIN_W];
  assign last_band      = (req_band == BAND_W'(NUM_BANDS-1));
  assign mac_accumulate = (state == RESP) && resp_valid;
  assign mac_clear      = (state == IDLE) && newsample;

  eq_gain_mac #(
    .SAMPLE_W (SAMPLE_W),
    .GAIN_W   (GAIN_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk        (clk),
    .nreset     (nreset),
    .clear      (mac_clear),
    .accumulate (mac_accumulate),
    .last       (last_band),
    .data       (resp_data),
    .gain       (band_gain),
    .result     (mac_result)
  );

  // The left sample lives in req_sample during the left pass, so only the right one is kept aside.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= IDLE;
      req_valid  <= 1'b0;
      req_band   <= '0;
      req_ch     <= 1'b0;
      req_sample <= '0;
      out_left   <= '0;
      out_right  <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      pend_valid <= 1'b0;
      pend_vals  <= '0;
      gains      <= GAIN_RESET;
      right_s    <= '0;
      left_res   <= '0;
    end else begin
      out_valid <= 1'b0;

      if (newsample && (state != IDLE))
        overrun <= 1'b1;

      // Gains are frozen for the whole frame; loads that arrive now wait in pend_vals.
      if (eq_load && ((state != IDLE) || newsample)) begin
        pend_valid <= 1'b1;
        pend_vals  <= eq_vals;
      end

      case (state)
        IDLE: begin
          if (newsample) begin
            right_s    <= right_in;
            req_sample <= left_in;
            req_band   <= '0;
            req_ch     <= 1'b0;
            req_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= REQ;
          end else if (eq_load) begin
            gains <= eq_vals;
          end
        end

        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= RESP;
          end
        end

        RESP: begin
          if (resp_valid) begin
            req_valid <= 1'b1;
            state     <= REQ;
            if (!last_band) begin
              req_band <= req_band + 1'b1;
            end else if (!req_ch) begin
              left_res   <= mac_result;
              req_band   <= '0;
              req_ch     <= 1'b1;
              req_sample <= right_s;
            end else begin
              req_valid <= 1'b0;
              req_band  <= '0;
              req_ch    <= 1'b0;
              out_left  <= left_res;
              out_right <= mac_result;
              out_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end

        OUT: begin
          busy       <= 1'b0;
          state      <= IDLE;
          pend_valid <= 1'b0;
          if (eq_load)
            gains <= eq_vals;
          else if (pend_valid)
            gains <= pend_vals;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
